// File: rtl/lynx_io_responder_if.sv
// CPU-side IO bus of the Lynx IO responder: request strobes, address/data and
// the wait/interrupt lines returned to the CPU.
interface lynx_io_responder_if;
  logic        iorq_n;
  logic        wr_n;
  logic [15:0] a;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        wait_n;
  logic        int_n;

  modport master (output iorq_n, wr_n, a, data_in, input data_out, wait_n, int_n);
  modport slave  (input iorq_n, wr_n, a, data_in, output data_out, wait_n, int_n);
endinterface

// File: rtl/lynx_io_responder.sv
// IO responder: bank/ctrl registers at 0x80/0x82, status/interrupt-ack at 0x84,
// programmable IO wait states and a periodic interrupt with bounded low time.
module lynx_io_responder #(
  parameter int INT_PERIOD = 80000,
  parameter int INT_LENGTH = 64,
  parameter int WAIT_IO    = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cep,
  lynx_io_responder_if.slave    bus,
  output logic [7:0]            bank,
  output logic [7:0]            ctrl
);

  localparam int IW = (INT_PERIOD > 1) ? $clog2(INT_PERIOD) : 1;
  localparam int LW = (INT_LENGTH > 0) ? $clog2(INT_LENGTH + 1) : 1;
  localparam logic [IW-1:0] ICNT_MAX  = IW'(INT_PERIOD - 1);
  localparam logic [LW-1:0] LEN_LOAD  = LW'(INT_LENGTH);
  localparam logic [3:0]    WAIT_LOAD = (WAIT_IO > 0) ? 4'(WAIT_IO - 1) : 4'd0;
  localparam bit            NO_WAIT   = (WAIT_IO == 0);

  localparam logic [7:0] PORT_BANK = 8'h80;
  localparam logic [7:0] PORT_CTRL = 8'h82;
  localparam logic [7:0] PORT_STAT = 8'h84;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_HOLD} state_t;

  state_t        state, state_nxt;
  logic [3:0]    wcnt, wcnt_nxt;
  logic          iorq_q;
  logic          armed;
  logic [IW-1:0] icnt;
  logic [LW-1:0] lcnt;
  logic          int_q;
  logic          start, commit, wrap, ack;
  logic [7:0]    port;
  logic          unused_addr_hi;

  assign port           = bus.a[7:0];
  assign unused_addr_hi = ^bus.a[15:8];

  // armed stays low after reset until iorq_n is seen high, so a request that
  // was already low across reset cannot masquerade as a fresh falling edge.
  assign start  = cep & ~bus.iorq_n & iorq_q & armed;
  assign commit = cep & (state == S_ACCESS) & ~bus.wr_n;
  assign wrap   = cep & (icnt == ICNT_MAX);
  assign ack    = commit & (port == PORT_STAT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      wcnt   <= 4'd0;
      iorq_q <= 1'b1;
      armed  <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (cep) begin
        iorq_q <= bus.iorq_n;
        if (bus.iorq_n) armed <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (NO_WAIT) begin
            state_nxt = S_ACCESS;
          end else begin
            state_nxt = S_WAIT;
            wcnt_nxt  = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cep) begin
          if (bus.iorq_n)       state_nxt = S_IDLE;
          else if (wcnt == 4'd0) state_nxt = S_ACCESS;
          else                  wcnt_nxt  = wcnt - 4'd1;
        end
      end
      S_ACCESS: if (cep) state_nxt = S_HOLD;
      S_HOLD:   if (cep && bus.iorq_n) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign bus.wait_n = (state != S_WAIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bank <= 8'h00;
      ctrl <= 8'h00;
    end else if (commit) begin
      case (port)
        PORT_BANK: bank <= bus.data_in;
        PORT_CTRL: ctrl <= bus.data_in;
        default: ;
      endcase
    end
  end

  // Wrap has priority over acknowledge: a new interrupt is never swallowed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      icnt  <= '0;
      lcnt  <= '0;
      int_q <= 1'b1;
    end else if (cep) begin
      icnt <= (icnt == ICNT_MAX) ? '0 : icnt + IW'(1);
      if (wrap) begin
        int_q <= 1'b0;
        lcnt  <= LEN_LOAD;
      end else if (ack) begin
        int_q <= 1'b1;
        lcnt  <= '0;
      end else if (lcnt != '0) begin
        lcnt <= lcnt - LW'(1);
        if (lcnt == LW'(1)) int_q <= 1'b1;
      end
    end
  end

  assign bus.int_n = int_q;

  always_comb begin
    bus.data_out = 8'hFF;
    if (!bus.iorq_n && bus.wr_n) begin
      case (port)
        PORT_BANK: bus.data_out = bank;
        PORT_CTRL: bus.data_out = ctrl;
        PORT_STAT: bus.data_out = {7'b0, ~int_q};
        default:   bus.data_out = 8'hFF;
      endcase
    end
  end

endmodule

// File: tb/tb_lynx_io_responder.sv
// Bench for lynx_io_responder: IO cycles scored against a register model,
// interrupt timing checked against tick counts from reset.
module tb_lynx_io_responder;
  localparam int P = 100;
  localparam int L = 10;
  localparam int W = 1;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       cep   = 1'b1;
  logic [7:0] bank, ctrl;

  lynx_io_responder_if bus();

  lynx_io_responder #(.INT_PERIOD(P), .INT_LENGTH(L), .WAIT_IO(W)) dut (
    .clock (clock),
    .reset (reset),
    .cep   (cep),
    .bus   (bus),
    .bank  (bank),
    .ctrl  (ctrl)
  );

  always #5 clock = ~clock;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] m_bank, m_ctrl;
  logic [7:0] exp_q[$];

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; bus.iorq_n = 1'b1; bus.wr_n = 1'b1; bus.a = 16'h0; bus.data_in = 8'h0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    m_bank = 8'h00; m_ctrl = 8'h00;
  endtask

  // Starts at a negedge; returns at the negedge after the cycle closes.
  task automatic io_write(input logic [15:0] addr, input logic [7:0] d);
    int wlow;
    logic [7:0] eb, ec;
    bus.a = addr; bus.data_in = d; bus.wr_n = 1'b0; bus.iorq_n = 1'b0;
    if (addr[7:0] == 8'h80) m_bank = d;
    if (addr[7:0] == 8'h82) m_ctrl = d;
    exp_q.push_back(m_bank);
    exp_q.push_back(m_ctrl);
    #1;
    total++;
    if (bus.data_out !== 8'hFF) begin bad++; $display("FAIL wr_data_out a=%h: got %h want ff", addr, bus.data_out); end
    wlow = 0;
    @(negedge clock);
    while (!bus.wait_n && wlow < 20) begin wlow++; @(negedge clock); end
    total++;
    if (wlow != W) begin bad++; $display("FAIL wait_len a=%h: got %0d want %0d", addr, wlow, W); end
    @(negedge clock);
    eb = exp_q.pop_front();
    ec = exp_q.pop_front();
    total++;
    if (bank !== eb || ctrl !== ec) begin
      bad++; $display("FAIL wr_regs a=%h: got bank=%h ctrl=%h want bank=%h ctrl=%h", addr, bank, ctrl, eb, ec);
    end
    bus.iorq_n = 1'b1; bus.wr_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic io_read(input logic [15:0] addr, input logic [7:0] exp);
    logic [7:0] e;
    bus.a = addr; bus.wr_n = 1'b1; bus.iorq_n = 1'b0;
    exp_q.push_back(exp);
    #1;
    e = exp_q.pop_front();
    total++;
    if (bus.data_out !== e) begin bad++; $display("FAIL rd a=%h: got %h want %h", addr, bus.data_out, e); end
    repeat (3) @(negedge clock);
    bus.iorq_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; bus.iorq_n = 1'b1; bus.wr_n = 1'b1; bus.a = 16'h0080; bus.data_in = 8'h0;
    #1;
    total++;
    if (bus.wait_n !== 1'b1 || bus.int_n !== 1'b1 || bank !== 8'h00 || ctrl !== 8'h00 || bus.data_out !== 8'hFF) begin
      bad++; $display("FAIL reset: got wait_n=%b int_n=%b bank=%h ctrl=%h dout=%h want 1 1 00 00 ff",
                      bus.wait_n, bus.int_n, bank, ctrl, bus.data_out);
    end
    @(negedge clock);
    reset = 1'b0;
    m_bank = 8'h00; m_ctrl = 8'h00;
    @(negedge clock);
  endtask

  task automatic test_write();
    io_write(16'h0080, 8'h5A);
  endtask

  task automatic test_cep_hold();
    bus.a = 16'h0082; bus.data_in = 8'h3C; bus.wr_n = 1'b0; bus.iorq_n = 1'b0;
    m_ctrl = 8'h3C;
    exp_q.push_back(m_ctrl);
    @(negedge clock);
    cep = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if (bus.wait_n !== 1'b0 || ctrl !== 8'h00) begin
      bad++; $display("FAIL cep_hold: got wait_n=%b ctrl=%h want 0 00", bus.wait_n, ctrl);
    end
    cep = 1'b1;
    repeat (2) @(negedge clock);
    total++;
    if (ctrl !== exp_q[0]) begin bad++; $display("FAIL cep_commit: got %h want %h", ctrl, exp_q[0]); end
    void'(exp_q.pop_front());
    bus.iorq_n = 1'b1; bus.wr_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_read();
    io_read(16'h0082, m_ctrl);
    io_read(16'h0090, 8'hFF);
    io_read(16'h0080, m_bank);
    bus.a = 16'h0080;
    #1;
    total++;
    if (bus.data_out !== 8'hFF) begin bad++; $display("FAIL idle_data_out: got %h want ff", bus.data_out); end
    @(negedge clock);
  endtask

  task automatic test_unmapped_write();
    io_write(16'h0090, 8'hEE);
    io_write(16'h0081, 8'hDD);
  endtask

  task automatic test_abort();
    int wlow;
    bus.a = 16'h0082; bus.data_in = 8'h77; bus.wr_n = 1'b0; bus.iorq_n = 1'b0;
    @(negedge clock);
    total++;
    if (bus.wait_n !== 1'b0) begin bad++; $display("FAIL abort_enter: got wait_n=%b want 0", bus.wait_n); end
    bus.iorq_n = 1'b1;
    @(negedge clock);
    total++;
    if (bus.wait_n !== 1'b1) begin bad++; $display("FAIL abort_release: got wait_n=%b want 1", bus.wait_n); end
    wlow = 0;
    repeat (3) begin @(negedge clock); if (!bus.wait_n) wlow++; end
    total++;
    if (ctrl !== m_ctrl || wlow != 0) begin
      bad++; $display("FAIL abort_commit: got ctrl=%h wlow=%0d want %h 0", ctrl, wlow, m_ctrl);
    end
    bus.wr_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    io_write(16'h0082, 8'hC3);
    io_write(16'h0080, 8'h96);
    io_read(16'h0080, m_bank);
    io_read(16'hFF82, m_ctrl);
  endtask

  task automatic test_reset_mid_cycle();
    int wlow;
    io_write(16'h0080, 8'h11);
    bus.a = 16'h0080; bus.data_in = 8'hA5; bus.wr_n = 1'b0; bus.iorq_n = 1'b0;
    @(negedge clock);
    total++;
    if (bus.wait_n !== 1'b0) begin bad++; $display("FAIL rst_mid_wait: got wait_n=%b want 0", bus.wait_n); end
    reset = 1'b1;
    #1;
    m_bank = 8'h00; m_ctrl = 8'h00;
    total++;
    if (bus.wait_n !== 1'b1 || bank !== 8'h00) begin
      bad++; $display("FAIL rst_mid_async: got wait_n=%b bank=%h want 1 00", bus.wait_n, bank);
    end
    @(negedge clock);
    reset = 1'b0;
    wlow = 0;
    repeat (6) begin @(negedge clock); if (!bus.wait_n) wlow++; end
    total++;
    if (bank !== 8'h00 || wlow != 0) begin
      bad++; $display("FAIL rst_mid_nostart: got bank=%h wlow=%0d want 00 0", bank, wlow);
    end
    bus.iorq_n = 1'b1; bus.wr_n = 1'b1;
    @(negedge clock);
    io_write(16'h0080, 8'hA5);
  endtask

  task automatic test_int_period();
    int first, second, len;
    logic prev;
    do_reset();
    first = -1; second = -1; len = -1; prev = 1'b1;
    for (int t = 1; t <= 230; t++) begin
      @(negedge clock);
      if (prev && !bus.int_n) begin
        if (first < 0) first = t; else if (second < 0) second = t;
      end
      if (!prev && bus.int_n && len < 0) len = t - first;
      prev = bus.int_n;
    end
    total++;
    if (first != P) begin bad++; $display("FAIL int_first: got %0d want %0d", first, P); end
    total++;
    if (len != L) begin bad++; $display("FAIL int_len: got %0d want %0d", len, L); end
    total++;
    if (second != 2 * P) begin bad++; $display("FAIL int_second: got %0d want %0d", second, 2 * P); end
    repeat (70) @(negedge clock);
    total++;
    if (bus.int_n !== 1'b0) begin bad++; $display("FAIL int_third: got int_n=%b want 0", bus.int_n); end
    io_read(16'h0084, 8'h01);
  endtask

  task automatic test_int_ack();
    int t;
    do_reset();
    t = 0;
    while (bus.int_n && t < 2 * P) begin @(negedge clock); t++; end
    total++;
    if (t != P) begin bad++; $display("FAIL ack_assert_tick: got %0d want %0d", t, P); end
    io_write(16'h0084, 8'h5C);
    total++;
    if (bus.int_n !== 1'b1) begin bad++; $display("FAIL ack_release: got int_n=%b want 1", bus.int_n); end
    io_read(16'h0084, 8'h00);
  endtask

  task automatic test_wrap_ack();
    do_reset();
    repeat (P - 3) @(negedge clock);
    io_write(16'h0084, 8'h00);
    total++;
    if (bus.int_n !== 1'b0) begin bad++; $display("FAIL wrap_ack_early: got int_n=%b want 0", bus.int_n); end
    repeat (L - 2) @(negedge clock);
    total++;
    if (bus.int_n !== 1'b0) begin bad++; $display("FAIL wrap_ack_last: got int_n=%b want 0", bus.int_n); end
    @(negedge clock);
    total++;
    if (bus.int_n !== 1'b1) begin bad++; $display("FAIL wrap_ack_end: got int_n=%b want 1", bus.int_n); end
  endtask

  initial begin
    bus.iorq_n = 1'b1; bus.wr_n = 1'b1; bus.a = 16'h0; bus.data_in = 8'h0;
    m_bank = 8'h00; m_ctrl = 8'h00;
    test_reset();
    test_write();
    test_cep_hold();
    test_read();
    test_unmapped_write();
    test_abort();
    test_back_to_back();
    test_reset_mid_cycle();
    test_int_period();
    test_int_ack();
    test_wrap_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/lynx_io_responder.md
LYNX_IO_RESPONDER -- requirements
Module: lynx_io_responder

Interface
REQ-001 The block SHALL have parameter INT_PERIOD, default 80000, giving the interrupt period in cep ticks.
REQ-002 The block SHALL have parameter INT_LENGTH, default 64, giving the maximum int_n low time in cep ticks without acknowledge.
REQ-003 The block SHALL have parameter WAIT_IO, default 1, giving the wait states inserted per IO cycle (range 0..15).
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset, with ports named as in the codebase.
REQ-005 clock  in  1  system clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 cep  in  1  CPU clock enable; all state advances only on cep=1 ticks.
REQ-008 iorq_n  in  1  CPU IO request, active low.
REQ-009 wr_n  in  1  CPU write strobe, active low.
REQ-010 a  in  16  CPU address; only a[7:0] decoded.
REQ-011 data_in  in  8  CPU write data.
REQ-012 data_out  out  8  read data to CPU.
REQ-013 wait_n  out  1  wait request to CPU, active low.
REQ-014 int_n  out  1  maskable interrupt to CPU, active low.
REQ-015 bank  out  8  memory bank register.
REQ-016 ctrl  out  8  video/control register.

Function
REQ-017 Ports (a[7:0]): 0x80 bank R/W, 0x82 ctrl R/W, 0x84 status read / interrupt-ack write; all other ports unmapped.
REQ-018 FSM states: IDLE, WAIT, ACCESS, HOLD.
REQ-019 IDLE->WAIT on a cep tick where iorq_n=0 and its registered previous value was 1, provided WAIT_IO>0; go directly to ACCESS if WAIT_IO=0.
REQ-020 In WAIT, wait_n SHALL be 0; a 4-bit counter loads WAIT_IO-1 on entry, decrements per cep tick, and the state moves to ACCESS on the tick where it reads 0.
REQ-021 In ACCESS, wait_n=1; if wr_n=0, commit data_in to the addressed register exactly once; then move to HOLD.
REQ-022 HOLD->IDLE on the first cep tick with iorq_n=1; no further commits within the same cycle.
REQ-023 If iorq_n rises during WAIT, the block SHALL return to IDLE, release wait_n the same tick and commit nothing.
REQ-024 data_out SHALL be combinational: addressed register value when iorq_n=0, wr_n=1 and port mapped; 0xFF otherwise.
REQ-025 Status read (0x84) SHALL return {7'b0, ~int_n}.
REQ-026 Interrupt counter: width ceil(log2(INT_PERIOD)) bits, counts 0..INT_PERIOD-1 on cep, wraps to 0.
REQ-027 On the wrap tick, int_n SHALL go 0 and a length counter SHALL load INT_LENGTH.
REQ-028 int_n SHALL return to 1 on an ACCESS-state write to 0x84 (any data) or when the length counter reaches 0, whichever occurs first.
REQ-029 A wrap and an acknowledge on the same tick: the wrap wins; int_n stays 0 and the length counter reloads.
REQ-030 Writes to unmapped ports SHALL be ignored; accesses to them still incur wait states.

Reset
REQ-031 While reset=1: state IDLE, wait_n=1, int_n=1, bank=0x00, ctrl=0x00, all counters 0, previous-iorq register 1.
REQ-032 Reset asserted mid-cycle SHALL abort it with no commit; after release, a still-low iorq_n SHALL NOT start a cycle until it goes high and low again.

Verification
REQ-033 Reset, then IO write a=0x0080 data 0x5A with WAIT_IO=1 -> wait_n low exactly 1 cep tick, bank=0x5A after ACCESS, ctrl unchanged.
REQ-034 IO read a=0x0082 after ctrl=0x3C -> data_out=0x3C while iorq_n=0; read a=0x0090 -> 0xFF.
REQ-035 INT_PERIOD=100, INT_LENGTH=10, no ack -> int_n low on cep tick 100 for exactly 10 ticks, repeating every 100 ticks.
REQ-036 Ack write to 0x84 three ticks after assertion -> int_n high the next clock; status read then returns 0x00.
REQ-037 Ack committed on the same tick as the wrap -> int_n remains 0 for a full INT_LENGTH.
REQ-038 reset pulsed during WAIT of a write to 0x80 with iorq_n held low -> bank=0x00, wait_n=1, no commit until a fresh iorq_n falling edge.
